implication_delay_checker: RTL and testbench

IMPLICATION_DELAY_CHECKER -- requirements
Module: implication_delay_checker

---
 rtl/implication_delay_checker_if.sv | 25 ++
 rtl/implication_delay_checker.sv | 108 ++++++++++
 tb/tb_implication_delay_checker.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/implication_delay_checker_if.sv
// Signal bundle for implication_delay_checker: stimulus in, check results out.
interface implication_delay_checker_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             ante;
    logic             cons;
    logic             clear;
    logic             viol;
    logic             fail;
    logic             pending;
    logic [1:0]       state;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] viol_cnt;

    modport master (
        output en, ante, cons, clear,
        input  viol, fail, pending, state, pass_cnt, viol_cnt
    );

    modport slave (
        input  en, ante, cons, clear,
        output viol, fail, pending, state, pass_cnt, viol_cnt
    );
endinterface

// File: rtl/implication_delay_checker.sv
// Synthesizable checker for "ante |-> ##DELAY cons" with pass/violation counters
// and a sticky failure state.
module implication_delay_checker #(
    parameter int unsigned DELAY = 1,
    parameter int unsigned CNT_W = 8
) (
    input logic                  CLK,
    input logic                  RESETN,
    implication_delay_checker_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTrack = 2'd1,
        StFail  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DELAY-1:0] ob_q, ob_d, ob_shift, ob_new;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
    logic             viol_q, viol_d;
    logic             load, eval, pass_ev, viol_ev;

    // State register
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= StIdle;
            ob_q       <= '0;
            pass_cnt_q <= '0;
            viol_cnt_q <= '0;
            viol_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ob_q       <= ob_d;
            pass_cnt_q <= pass_cnt_d;
            viol_cnt_q <= viol_cnt_d;
            viol_q     <= viol_d;
        end
    end

    // Obligation pipeline: the oldest entry is evaluated against cons this cycle.
    always_comb begin
        load      = bus.en & bus.ante;
        eval      = ob_q[DELAY-1];
        pass_ev   = eval & bus.cons;
        viol_ev   = eval & ~bus.cons;
        ob_new    = '0;
        ob_new[0] = load;
        ob_shift  = (ob_q << 1) | ob_new;

        ob_d       = ob_shift;
        viol_d     = viol_ev;
        pass_cnt_d = pass_cnt_q;
        viol_cnt_d = viol_cnt_q;
        if (pass_ev && (pass_cnt_q != '1)) begin
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end
        if (viol_ev && (viol_cnt_q != '1)) begin
            viol_cnt_d = viol_cnt_q + CNT_W'(1);
        end

        // Clear discards the evaluation and the new antecedent of this cycle.
        if (bus.clear) begin
            ob_d       = '0;
            viol_d     = 1'b0;
            pass_cnt_d = '0;
            viol_cnt_d = '0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (viol_ev) begin
                    state_d = StFail;
                end else if (load) begin
                    state_d = StTrack;
                end
            end
            StTrack: begin
                if (viol_ev) begin
                    state_d = StFail;
                end else if (ob_shift == '0) begin
                    state_d = StIdle;
                end
            end
            StFail:  state_d = StFail;
            default: state_d = StIdle;
        endcase
        if (bus.clear) begin
            state_d = StIdle;
        end
    end

    // Outputs
    always_comb begin
        bus.viol     = viol_q;
        bus.fail     = (state_q == StFail);
        bus.pending  = |ob_q;
        bus.state    = state_q;
        bus.pass_cnt = pass_cnt_q;
        bus.viol_cnt = viol_cnt_q;
    end

endmodule

// File: tb/tb_implication_delay_checker.sv
// Directed, table-driven bench for implication_delay_checker at DELAY=1 (CNT_W=2),
// DELAY=2 and DELAY=3, sharing one stimulus stream.
module tb_implication_delay_checker;

    localparam int unsigned D1 = 0;  // DELAY=1, CNT_W=2
    localparam int unsigned D2 = 1;  // DELAY=2, CNT_W=8
    localparam int unsigned D3 = 2;  // DELAY=3, CNT_W=8

    // Input codes {RESETN, en, ante, cons, clear}
    localparam logic [4:0] R    = 5'b00000;
    localparam logic [4:0] I0   = 5'b10000;
    localparam logic [4:0] A    = 5'b11100;
    localparam logic [4:0] AC   = 5'b11110;
    localparam logic [4:0] C    = 5'b10010;
    localparam logic [4:0] N    = 5'b10100;
    localparam logic [4:0] CLR  = 5'b10001;
    localparam logic [4:0] CLRA = 5'b11101;

    logic CLK = 1'b0;
    logic RESETN, en, ante, cons, clear;

    always #5 CLK = ~CLK;

    implication_delay_checker_if #(.CNT_W(2)) bus1 ();
    implication_delay_checker_if #(.CNT_W(8)) bus2 ();
    implication_delay_checker_if #(.CNT_W(8)) bus3 ();

    assign bus1.en = en;  assign bus1.ante = ante;  assign bus1.cons = cons;  assign bus1.clear = clear;
    assign bus2.en = en;  assign bus2.ante = ante;  assign bus2.cons = cons;  assign bus2.clear = clear;
    assign bus3.en = en;  assign bus3.ante = ante;  assign bus3.cons = cons;  assign bus3.clear = clear;

    implication_delay_checker #(.DELAY(1), .CNT_W(2)) u_d1 (.CLK(CLK), .RESETN(RESETN), .bus(bus1));
    implication_delay_checker #(.DELAY(2), .CNT_W(8)) u_d2 (.CLK(CLK), .RESETN(RESETN), .bus(bus2));
    implication_delay_checker #(.DELAY(3), .CNT_W(8)) u_d3 (.CLK(CLK), .RESETN(RESETN), .bus(bus3));

    typedef struct {
        int unsigned sel;
        logic [4:0]  in;
        logic        chk;
        logic [2:0]  flg;   // {viol, fail, pending}
        logic [1:0]  st;
        logic [7:0]  pc;
        logic [7:0]  vc;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input int unsigned sel, input logic [4:0] in, input logic chk,
                       input logic [2:0] flg, input logic [1:0] st,
                       input logic [7:0] pc, input logic [7:0] vc);
        vec_t v;
        v.sel = sel; v.in = in; v.chk = chk; v.flg = flg; v.st = st; v.pc = pc; v.vc = vc;
        vecs.push_back(v);
    endtask

    function automatic logic [20:0] observe(input int unsigned sel);
        case (sel)
            D1: return {bus1.viol, bus1.fail, bus1.pending, bus1.state,
                        6'd0, bus1.pass_cnt, 6'd0, bus1.viol_cnt};
            D2: return {bus2.viol, bus2.fail, bus2.pending, bus2.state, bus2.pass_cnt, bus2.viol_cnt};
            default: return {bus3.viol, bus3.fail, bus3.pending, bus3.state,
                             bus3.pass_cnt, bus3.viol_cnt};
        endcase
    endfunction

    task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got viol/fail/pend=%b state=%0d pass=%0d vcnt=%0d, expected viol/fail/pend=%b state=%0d pass=%0d vcnt=%0d",
                     name, got[20:18], got[17:16], got[15:8], got[7:0],
                     exp[20:18], exp[17:16], exp[15:8], exp[7:0]);
        end
    endtask

    initial begin
        int          lat;
        logic [20:0] got;

        {RESETN, en, ante, cons, clear} = R;

        // Single obligation discharged (DELAY=1)
        add(D1, R,   0, 3'b000, 0, 0, 0);
        add(D1, A,   1, 3'b000, 0, 0, 0);
        add(D1, C,   1, 3'b001, 1, 0, 0);
        add(D1, I0,  1, 3'b000, 0, 1, 0);
        // Single violation, sticky fail (DELAY=1)
        add(D1, R,   0, 3'b000, 0, 0, 0);
        add(D1, A,   1, 3'b000, 0, 0, 0);
        add(D1, I0,  1, 3'b001, 1, 0, 0);
        add(D1, I0,  1, 3'b110, 2, 0, 1);
        add(D1, I0,  1, 3'b010, 2, 0, 1);
        // Violation counter saturates at 3, then clear from FAIL
        add(D1, R,   0, 3'b000, 0, 0, 0);
        add(D1, A,   1, 3'b000, 0, 0, 0);
        add(D1, A,   1, 3'b001, 1, 0, 0);
        add(D1, A,   1, 3'b111, 2, 0, 1);
        add(D1, A,   1, 3'b111, 2, 0, 2);
        add(D1, A,   1, 3'b111, 2, 0, 3);
        add(D1, A,   1, 3'b111, 2, 0, 3);
        add(D1, I0,  1, 3'b111, 2, 0, 3);
        add(D1, I0,  1, 3'b110, 2, 0, 3);
        add(D1, CLR, 1, 3'b010, 2, 0, 3);
        add(D1, I0,  1, 3'b000, 0, 0, 0);
        // Pass counter saturates at 3
        add(D1, R,   0, 3'b000, 0, 0, 0);
        add(D1, AC,  1, 3'b000, 0, 0, 0);
        add(D1, AC,  1, 3'b001, 1, 0, 0);
        add(D1, AC,  1, 3'b001, 1, 1, 0);
        add(D1, AC,  1, 3'b001, 1, 2, 0);
        add(D1, C,   1, 3'b001, 1, 3, 0);
        add(D1, I0,  1, 3'b000, 0, 3, 0);
        // Overlapping obligations, DELAY=3: cons 1,0,1
        add(D3, R,   0, 3'b000, 0, 0, 0);
        add(D3, A,   1, 3'b000, 0, 0, 0);
        add(D3, A,   1, 3'b001, 1, 0, 0);
        add(D3, A,   1, 3'b001, 1, 0, 0);
        add(D3, C,   1, 3'b001, 1, 0, 0);
        add(D3, I0,  1, 3'b001, 1, 1, 0);
        add(D3, C,   1, 3'b111, 2, 1, 1);
        add(D3, I0,  1, 3'b010, 2, 2, 1);
        add(D3, I0,  1, 3'b010, 2, 2, 1);
        // Clear discards outstanding obligation (DELAY=2)
        add(D2, R,   0, 3'b000, 0, 0, 0);
        add(D2, A,   1, 3'b000, 0, 0, 0);
        add(D2, CLR, 1, 3'b001, 1, 0, 0);
        add(D2, I0,  1, 3'b000, 0, 0, 0);
        add(D2, I0,  1, 3'b000, 0, 0, 0);
        // Clear beats a simultaneous failing evaluation and new antecedent
        add(D2, A,   1, 3'b000, 0, 0, 0);
        add(D2, I0,  1, 3'b001, 1, 0, 0);
        add(D2, CLRA,1, 3'b001, 1, 0, 0);
        add(D2, I0,  1, 3'b000, 0, 0, 0);
        add(D2, I0,  1, 3'b000, 0, 0, 0);
        // Reset mid-operation discards obligation; en=0 blocks new ones
        add(D2, R,   0, 3'b000, 0, 0, 0);
        add(D2, A,   1, 3'b000, 0, 0, 0);
        add(D2, R,   1, 3'b001, 1, 0, 0);
        add(D2, I0,  1, 3'b000, 0, 0, 0);
        add(D2, I0,  1, 3'b000, 0, 0, 0);
        add(D2, N,   1, 3'b000, 0, 0, 0);
        add(D2, N,   1, 3'b000, 0, 0, 0);
        add(D2, I0,  1, 3'b000, 0, 0, 0);
        // en=0 still evaluates outstanding; violation and new antecedent coexist
        add(D2, R,   0, 3'b000, 0, 0, 0);
        add(D2, A,   1, 3'b000, 0, 0, 0);
        add(D2, N,   1, 3'b001, 1, 0, 0);
        add(D2, A,   1, 3'b001, 1, 0, 0);
        add(D2, C,   1, 3'b111, 2, 0, 1);
        add(D2, C,   1, 3'b011, 2, 0, 1);
        add(D2, I0,  1, 3'b010, 2, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            {RESETN, en, ante, cons, clear} = vecs[i].in;
            if (vecs[i].chk) begin
                got = observe(vecs[i].sel);
                check($sformatf("row%0d_dut%0d", i, vecs[i].sel + 1), got,
                      {vecs[i].flg, vecs[i].st, vecs[i].pc, vecs[i].vc});
            end
        end

        // Violation latency on DELAY=3 is DELAY+1 cycles after the antecedent
        @(negedge CLK); {RESETN, en, ante, cons, clear} = R;
        @(negedge CLK); {RESETN, en, ante, cons, clear} = A;
        @(negedge CLK); {RESETN, en, ante, cons, clear} = I0;
        lat = 1;
        while (!bus3.viol && lat < 12) begin
            @(negedge CLK);
            lat++;
        end
        check("viol_latency_d3", {13'd0, 8'(lat)}, {13'd0, 8'd4});
        check("viol_cycle_d3", observe(D3), {3'b110, 2'd2, 8'd0, 8'd1});
        @(negedge CLK);
        check("viol_pulse_end_d3", observe(D3), {3'b010, 2'd2, 8'd0, 8'd1});

        // Reset overrides clear/en/ante
        {RESETN, en, ante, cons, clear} = 5'b01101;
        @(negedge CLK);
        {RESETN, en, ante, cons, clear} = I0;
        check("reset_override_d3", observe(D3), 21'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
